// File: rtl/multi_ch_counter_pkg.sv
// Shared types for the multi-channel start/target counter.
// Holds the per-channel state encoding and the mode values sampled at start.
package multi_ch_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_channel.sv
// One timer channel: start/target counter with one-shot or auto-reload mode,
// abort, pause, a 1-cycle done pulse and a sticky done flag.
//
// state   | meaning
// ST_IDLE | not counting; cnt holds 0 or the last reached target
// ST_RUN  | counting toward tgt; frozen while pause_i is high
module counter_channel
  import multi_ch_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] cnt_val_i,
  input  logic                 pause_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 status_o
);

  localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_tgt;
  logic                 r_mode;
  logic                 r_done;
  logic                 r_status;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_tgt_nxt;
  logic                 w_mode_nxt;
  logic                 w_done_nxt;
  logic                 w_status_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= ZERO;
      r_tgt    <= ZERO;
      r_mode   <= MODE_ONESHOT;
      r_done   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tgt    <= w_tgt_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
      r_status <= w_status_nxt;
    end
  end

  // A periodic channel sitting at tgt wraps to 1, keeping pulses exactly tgt apart.
  assign w_cnt_step = (r_cnt == r_tgt) ? ONE : r_cnt + ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    if (stop_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = ZERO;
    end else if (start_i) begin
      w_tgt_nxt  = cnt_val_i;
      w_mode_nxt = mode_i;
      w_cnt_nxt  = ZERO;
      if (cnt_val_i == ZERO) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else if (r_state == ST_RUN && !pause_i) begin
      w_cnt_nxt = w_cnt_step;
      if (w_cnt_step == r_tgt) begin
        w_done_nxt = 1'b1;
        if (r_mode == MODE_ONESHOT) begin
          w_state_nxt = ST_IDLE;
        end
      end
    end
    w_status_nxt = w_done_nxt | (r_status & ~clr_i);
  end

  assign cnt_o    = r_cnt;
  assign busy_o   = (r_state == ST_RUN);
  assign done_o   = r_done;
  assign status_o = r_status;

endmodule

// File: rtl/multi_ch_counter.sv
// NUM_CH independent start/target timer channels sharing one clock.
// Top level only slices the packed buses and ORs the sticky flags into irq_o.
module multi_ch_counter
  import multi_ch_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 7,
  parameter int NUM_CH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           start_i,
  input  logic [NUM_CH-1:0]           stop_i,
  input  logic [NUM_CH-1:0]           mode_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val_i,
  input  logic                        pause_i,
  input  logic [NUM_CH-1:0]           clr_i,
  output logic [NUM_CH*CNT_WIDTH-1:0] cnt_o,
  output logic [NUM_CH-1:0]           busy_o,
  output logic [NUM_CH-1:0]           done_o,
  output logic [NUM_CH-1:0]           status_o,
  output logic                        irq_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    counter_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i[k]),
      .stop_i    (stop_i[k]),
      .mode_i    (mode_i[k]),
      .cnt_val_i (cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH]),
      .pause_i   (pause_i),
      .clr_i     (clr_i[k]),
      .cnt_o     (cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .busy_o    (busy_o[k]),
      .done_o    (done_o[k]),
      .status_o  (status_o[k])
    );
  end

  assign irq_o = |status_o;

endmodule

// File: tb/tb_multi_ch_counter.sv
// Directed bench for multi_ch_counter: one-shot, periodic, pause, stop,
// degenerate zero target, restart, set/clear priority and reset.
module tb_multi_ch_counter;

  localparam int CW = 7;
  localparam int NC = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC-1:0]    start_i;
  logic [NC-1:0]    stop_i;
  logic [NC-1:0]    mode_i;
  logic [NC*CW-1:0] cnt_val_i;
  logic             pause_i;
  logic [NC-1:0]    clr_i;
  logic [NC*CW-1:0] cnt_o;
  logic [NC-1:0]    busy_o;
  logic [NC-1:0]    done_o;
  logic [NC-1:0]    status_o;
  logic             irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  multi_ch_counter #(.CNT_WIDTH(CW), .NUM_CH(NC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .cnt_val_i (cnt_val_i),
    .pause_i   (pause_i),
    .clr_i     (clr_i),
    .cnt_o     (cnt_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .status_o  (status_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ch_cnt(input int k);
    return cnt_o[k*CW +: CW];
  endfunction

  task automatic set_tgt(input int k, input int v);
    cnt_val_i[k*CW +: CW] = CW'(v);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start_i = '0; stop_i = '0; mode_i = '0;
    cnt_val_i = '0; pause_i = 1'b0; clr_i = '0;
    tick(); tick();
    check("rst_cnt", 32'(cnt_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_status", 32'(status_o), 0);
    check("rst_irq", 32'(irq_o), 0);
    rst_n = 1'b1;
    tick();

    // 1: ch0 one-shot to 100
    set_tgt(0, 100); mode_i[0] = 1'b0; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    check("t1_cnt_start", 32'(ch_cnt(0)), 0);
    check("t1_busy_start", 32'(busy_o[0]), 1);
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      check("t1_cnt", 32'(ch_cnt(0)), 32'(i));
      check("t1_done", 32'(done_o[0]), (i == 100) ? 1 : 0);
      check("t1_busy", 32'(busy_o[0]), (i == 100) ? 0 : 1);
      if (done_o[0]) pulses++;
    end
    check("t1_pulses", 32'(pulses), 1);
    tick();
    check("t1_done_after", 32'(done_o[0]), 0);
    check("t1_cnt_hold", 32'(ch_cnt(0)), 100);
    check("t1_status", 32'(status_o), 32'h1);
    check("t1_irq", 32'(irq_o), 1);
    clr_i[0] = 1'b1;
    tick();
    clr_i[0] = 1'b0;
    check("t1_status_clr", 32'(status_o), 0);
    check("t1_irq_clr", 32'(irq_o), 0);

    // 2: ch1 periodic with target 5
    set_tgt(1, 5); mode_i[1] = 1'b1; start_i[1] = 1'b1;
    tick();
    start_i[1] = 1'b0;
    check("t2_cnt_start", 32'(ch_cnt(1)), 0);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t2_cnt", 32'(ch_cnt(1)), 32'(((i - 1) % 5) + 1));
      check("t2_done", 32'(done_o[1]), (i % 5 == 0) ? 1 : 0);
      check("t2_busy", 32'(busy_o[1]), 1);
      if (done_o[1]) pulses++;
    end
    check("t2_pulses", 32'(pulses), 4);
    stop_i[1] = 1'b1;
    tick();
    stop_i[1] = 1'b0;
    check("t2_stop_cnt", 32'(ch_cnt(1)), 0);
    check("t2_stop_busy", 32'(busy_o[1]), 0);
    check("t2_status_kept", 32'(status_o[1]), 1);
    clr_i[1] = 1'b1;
    tick();
    clr_i[1] = 1'b0;

    // 3: ch2 target 10 with a 3-cycle pause after count 4
    set_tgt(2, 10); mode_i[2] = 1'b0; start_i[2] = 1'b1;
    tick();
    start_i[2] = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("t3_cnt_pre", 32'(ch_cnt(2)), 4);
    pause_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_cnt_paused", 32'(ch_cnt(2)), 4);
      check("t3_done_paused", 32'(done_o[2]), 0);
      check("t3_busy_paused", 32'(busy_o[2]), 1);
    end
    pause_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t3_cnt_resume", 32'(ch_cnt(2)), 32'(4 + i));
      check("t3_done_resume", 32'(done_o[2]), (i == 6) ? 1 : 0);
    end
    clr_i[2] = 1'b1;
    tick();
    clr_i[2] = 1'b0;

    // 4: ch0 stop at count 20, then start and stop together
    set_tgt(0, 50); mode_i[0] = 1'b0; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    check("t4_cnt20", 32'(ch_cnt(0)), 20);
    stop_i[0] = 1'b1;
    tick();
    stop_i[0] = 1'b0;
    check("t4_stop_cnt", 32'(ch_cnt(0)), 0);
    check("t4_stop_busy", 32'(busy_o[0]), 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o[0]) pulses++;
    end
    check("t4_no_done", 32'(pulses), 0);
    check("t4_cnt_idle", 32'(ch_cnt(0)), 0);
    start_i[0] = 1'b1; stop_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0; stop_i[0] = 1'b0;
    check("t4_ss_busy", 32'(busy_o[0]), 0);
    check("t4_ss_cnt", 32'(ch_cnt(0)), 0);
    check("t4_ss_done", 32'(done_o[0]), 0);
    tick();
    check("t4_ss_busy2", 32'(busy_o[0]), 0);
    check("t4_status", 32'(status_o), 0);

    // 5: ch3 zero target gives immediate done
    set_tgt(3, 0); start_i[3] = 1'b1;
    tick();
    start_i[3] = 1'b0;
    check("t5_done", 32'(done_o[3]), 1);
    check("t5_busy", 32'(busy_o[3]), 0);
    check("t5_cnt", 32'(ch_cnt(3)), 0);
    tick();
    check("t5_done_off", 32'(done_o[3]), 0);
    check("t5_busy2", 32'(busy_o[3]), 0);
    check("t5_status", 32'(status_o), 32'h8);
    check("t5_irq", 32'(irq_o), 1);
    clr_i[3] = 1'b1;
    tick();
    clr_i[3] = 1'b0;
    check("t5_status_clr", 32'(status_o[3]), 0);
    check("t5_irq_clr", 32'(irq_o), 0);

    // set and clear on the same edge: set wins (ch1 periodic target 2)
    set_tgt(1, 2); mode_i[1] = 1'b1; start_i[1] = 1'b1;
    tick();
    start_i[1] = 1'b0;
    tick();
    check("sc_cnt1", 32'(ch_cnt(1)), 1);
    clr_i[1] = 1'b1;
    tick();
    clr_i[1] = 1'b0;
    check("sc_done", 32'(done_o[1]), 1);
    check("sc_status", 32'(status_o[1]), 1);
    stop_i[1] = 1'b1;
    tick();
    stop_i[1] = 1'b0; clr_i[1] = 1'b1;
    tick();
    clr_i[1] = 1'b0;
    check("sc_status_clr", 32'(status_o[1]), 0);

    // restart in RUN reloads target, aborted run produces no done
    set_tgt(2, 10); mode_i[2] = 1'b0; start_i[2] = 1'b1;
    tick();
    start_i[2] = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    set_tgt(2, 3); start_i[2] = 1'b1;
    tick();
    start_i[2] = 1'b0;
    check("rs_cnt0", 32'(ch_cnt(2)), 0);
    check("rs_busy", 32'(busy_o[2]), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rs_done", 32'(done_o[2]), (i == 3) ? 1 : 0);
    end
    check("rs_cnt3", 32'(ch_cnt(2)), 3);
    clr_i[2] = 1'b1;
    tick();
    clr_i[2] = 1'b0;

    // 6: all channels running, then reset mid-run
    set_tgt(0, 30); set_tgt(1, 40); set_tgt(2, 50); set_tgt(3, 60);
    mode_i = 4'b1010; start_i = 4'hF;
    tick();
    start_i = '0;
    for (int i = 1; i <= 10; i++) tick();
    check("t6_busy", 32'(busy_o), 32'hF);
    check("t6_cnt", 32'(cnt_o), {4'b0, 7'd10, 7'd10, 7'd10, 7'd10});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_cnt", 32'(cnt_o), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_done", 32'(done_o), 0);
    check("t6_rst_status", 32'(status_o), 0);
    check("t6_rst_irq", 32'(irq_o), 0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done_o != '0 || busy_o != '0) pulses++;
    end
    check("t6_quiet", 32'(pulses), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
